// File: rtl/peak_event_tracker.sv
// peak_event_tracker
//   Watches a monotonic running-maximum stream. Each time the peak rises it
//   queues an event {new peak, samples the previous peak held} in a small
//   FIFO, which a slow consumer drains through a valid/ready handshake.
//   It also flags saturation (peak reached all-ones) and protocol errors
//   (a sample below the tracked peak).
// Ports
//   clk       in   clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   in_valid  in   in_max carries a sample this cycle
//   in_max    in   [W-1:0] running max from upstream
//   ev_valid  out  FIFO head valid
//   ev_ready  in   consumer accepts head when ev_valid & ev_ready
//   ev_value  out  [W-1:0] peak value of head event
//   ev_hold   out  [CNT_W-1:0] samples the previous peak held (0 for first)
//   ev_level  out  FIFO occupancy, 0..FIFO_DEPTH
//   peak_sat  out  tracked peak is all-ones
//   err_dec   out  sticky: sample below tracked peak seen
//   ovf       out  sticky: event dropped because FIFO was full
module peak_event_tracker #(
    parameter int W          = 2,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [W-1:0]                    in_max,
    output logic                            ev_valid,
    input  logic                            ev_ready,
    output logic [W-1:0]                    ev_value,
    output logic [CNT_W-1:0]                ev_hold,
    output logic [$clog2(FIFO_DEPTH):0]     ev_level,
    output logic                            peak_sat,
    output logic                            err_dec,
    output logic                            ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_SAT   = 2'd2;

    localparam logic [W-1:0]     PEAK_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     peak_q, peak_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic [W-1:0]     val_mem_q  [FIFO_DEPTH];
    logic [CNT_W-1:0] hold_mem_q [FIFO_DEPTH];

    logic             push;
    logic [CNT_W-1:0] push_hold;
    logic             pop;
    logic             full;
    logic             accept;

    // Peak tracking and event generation
    always_comb begin
        state_d   = state_q;
        peak_d    = peak_q;
        hold_d    = hold_q;
        err_d     = err_q;
        push      = 1'b0;
        push_hold = hold_q;
        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    push      = 1'b1;
                    push_hold = '0;
                    peak_d    = in_max;
                    hold_d    = CNT_ONE;
                    state_d   = (in_max == PEAK_MAX) ? ST_SAT : ST_TRACK;
                end
                ST_TRACK: begin
                    if (in_max > peak_q) begin
                        push    = 1'b1;
                        peak_d  = in_max;
                        hold_d  = CNT_ONE;
                        state_d = (in_max == PEAK_MAX) ? ST_SAT : ST_TRACK;
                    end else if (in_max == peak_q) begin
                        if (hold_q != CNT_MAX) hold_d = hold_q + CNT_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_SAT: begin
                    // Peak is all-ones, so a sample can only match or fall below.
                    if (in_max == peak_q) begin
                        if (hold_q != CNT_MAX) hold_d = hold_q + CNT_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping; a pop in the same cycle frees room for a push when full
    always_comb begin
        pop      = (level_q != '0) && ev_ready;
        full     = (level_q == LVL_FULL);
        accept   = push && (!full || pop);
        ovf_d    = ovf_q || (push && full && !pop);
        wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({accept, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            peak_q   <= '0;
            hold_q   <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                val_mem_q[i]  <= '0;
                hold_mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            peak_q   <= peak_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (accept) begin
                val_mem_q[wr_ptr_q]  <= in_max;
                hold_mem_q[wr_ptr_q] <= push_hold;
            end
        end
    end

    assign ev_valid = (level_q != '0);
    assign ev_value = val_mem_q[rd_ptr_q];
    assign ev_hold  = hold_mem_q[rd_ptr_q];
    assign ev_level = level_q;
    assign peak_sat = (state_q == ST_SAT);
    assign err_dec  = err_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_peak_event_tracker.sv
// Directed bench for peak_event_tracker. A default-parameter instance covers
// tracking, draining, errors, hold saturation and reset; a W=3 instance
// provides enough distinct peaks to overrun the 4-entry FIFO.
module tb_peak_event_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       ev_ready;
    logic [1:0] in_max;
    logic [2:0] in_max3;

    logic       ev_valid, peak_sat, err_dec, ovf;
    logic [1:0] ev_value;
    logic [7:0] ev_hold;
    logic [2:0] ev_level;

    logic       ev_valid3, peak_sat3, err_dec3, ovf3;
    logic [2:0] ev_value3;
    logic [7:0] ev_hold3;
    logic [2:0] ev_level3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    peak_event_tracker #(.W(2), .CNT_W(8), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_max(in_max),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_value(ev_value),
        .ev_hold(ev_hold), .ev_level(ev_level), .peak_sat(peak_sat),
        .err_dec(err_dec), .ovf(ovf)
    );

    peak_event_tracker #(.W(3), .CNT_W(8), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_max(in_max3),
        .ev_valid(ev_valid3), .ev_ready(ev_ready), .ev_value(ev_value3),
        .ev_hold(ev_hold3), .ev_level(ev_level3), .peak_sat(peak_sat3),
        .err_dec(err_dec3), .ovf(ovf3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst      = 1'b0;
    endtask

    task automatic sample(input logic [1:0] v);
        in_valid = 1'b1;
        in_max   = v;
        step();
    endtask

    task automatic sample3(input logic [2:0] v);
        in_valid = 1'b1;
        in_max3  = v;
        step();
    endtask

    task automatic check_head(input string tag, input logic [1:0] v, input logic [7:0] h);
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_value"}, 32'(ev_value), 32'(v));
        check({tag, "_hold"}, 32'(ev_hold), 32'(h));
    endtask

    task automatic check_head3(input string tag, input logic [2:0] v, input logic [7:0] h);
        check({tag, "_valid"}, 32'(ev_valid3), 32'd1);
        check({tag, "_value"}, 32'(ev_value3), 32'(v));
        check({tag, "_hold"}, 32'(ev_hold3), 32'(h));
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        ev_ready = 1'b0;
        in_max   = '0;
        in_max3  = '0;

        // Reset state
        do_reset();
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_level", 32'(ev_level), 32'd0);
        check("rst_value", 32'(ev_value), 32'd0);
        check("rst_hold", 32'(ev_hold), 32'd0);
        check("rst_sat", 32'(peak_sat), 32'd0);
        check("rst_err", 32'(err_dec), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // T1: streaming consumer, events (0,0),(1,1),(2,2),(3,3)
        ev_ready = 1'b1;
        sample(2'd0); check_head("t1_e0", 2'd0, 8'd0);
        sample(2'd1); check_head("t1_e1", 2'd1, 8'd1);
        check("t1_lvl1", 32'(ev_level), 32'd1);
        sample(2'd1); check("t1_empty_a", 32'(ev_valid), 32'd0);
        sample(2'd2); check_head("t1_e2", 2'd2, 8'd2);
        sample(2'd2);
        sample(2'd2);
        check("t1_sat_before", 32'(peak_sat), 32'd0);
        sample(2'd3); check_head("t1_e3", 2'd3, 8'd3);
        check("t1_sat", 32'(peak_sat), 32'd1);
        in_valid = 1'b0;
        step();
        check("t1_level_end", 32'(ev_level), 32'd0);
        check("t1_err", 32'(err_dec), 32'd0);
        check("t1_ovf", 32'(ovf), 32'd0);

        // T2: fill four events with consumer stalled, then drain in order
        do_reset();
        ev_ready = 1'b0;
        sample(2'd0);
        sample(2'd1);
        sample(2'd2);
        sample(2'd3);
        in_valid = 1'b0;
        check("t2_level_full", 32'(ev_level), 32'd4);
        check("t2_ovf", 32'(ovf), 32'd0);
        step();
        check_head("t2_stall_head", 2'd0, 8'd0);
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("t2_drain%0d", i), 2'(i), (i == 0) ? 8'd0 : 8'd1);
            check($sformatf("t2_lvl%0d", i), 32'(ev_level), 32'(4 - i));
            step();
        end
        check("t2_empty", 32'(ev_valid), 32'd0);
        check("t2_level0", 32'(ev_level), 32'd0);

        // T3 (W=3): overflow when full without pop; no overflow with same-cycle pop
        do_reset();
        ev_ready = 1'b0;
        sample3(3'd0);
        sample3(3'd1);
        sample3(3'd2);
        sample3(3'd3);
        check("t3_level_full", 32'(ev_level3), 32'd4);
        check("t3_ovf_pre", 32'(ovf3), 32'd0);
        sample3(3'd4);
        check("t3_ovf", 32'(ovf3), 32'd1);
        check("t3_level_stay", 32'(ev_level3), 32'd4);
        check_head3("t3_head_kept", 3'd0, 8'd0);
        in_valid = 1'b0;
        step();
        check("t3_ovf_sticky", 32'(ovf3), 32'd1);

        do_reset();
        check("t3_ovf_cleared", 32'(ovf3), 32'd0);
        sample3(3'd0);
        sample3(3'd1);
        sample3(3'd2);
        sample3(3'd3);
        ev_ready = 1'b1;
        sample3(3'd4);
        in_valid = 1'b0;
        check("t3_pp_ovf", 32'(ovf3), 32'd0);
        check("t3_pp_level", 32'(ev_level3), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check_head3($sformatf("t3_drain%0d", i), 3'(i), 8'd1);
            step();
        end
        check("t3_drained", 32'(ev_level3), 32'd0);

        // T4: decrease flags err_dec, does not touch hold count or emit
        do_reset();
        ev_ready = 1'b1;
        sample(2'd2); check_head("t4_first", 2'd2, 8'd0);
        sample(2'd1);
        check("t4_err", 32'(err_dec), 32'd1);
        check("t4_no_event", 32'(ev_valid), 32'd0);
        sample(2'd2);
        sample(2'd3); check_head("t4_next", 2'd3, 8'd2);
        check("t4_err_sticky", 32'(err_dec), 32'd1);

        // T5: hold count saturates at 255
        do_reset();
        ev_ready = 1'b1;
        for (int i = 0; i < 300; i++) sample(2'd1);
        sample(2'd2); check_head("t5_sat_hold", 2'd2, 8'd255);

        // T6: reset with events queued and err set
        do_reset();
        ev_ready = 1'b0;
        sample(2'd0);
        sample(2'd1);
        sample(2'd2);
        sample(2'd1);
        check("t6_level_pre", 32'(ev_level), 32'd3);
        check("t6_err_pre", 32'(err_dec), 32'd1);
        in_valid = 1'b1;
        in_max   = 2'd3;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        check("t6_valid", 32'(ev_valid), 32'd0);
        check("t6_level", 32'(ev_level), 32'd0);
        check("t6_err", 32'(err_dec), 32'd0);
        check("t6_sat", 32'(peak_sat), 32'd0);
        sample(2'd2); check_head("t6_first", 2'd2, 8'd0);
        check("t6_level1", 32'(ev_level), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
